// File: rtl/pow_seq.sv
// Square-and-multiply sequencer computing y = x^n (IEEE-754 single) through a shared,
// externally registered multiplier. Optional zero/denormal bypass: define POW_ZERO_BYPASS_EN.
module pow_seq #(
  parameter int N_W     = 8,
  parameter int MUL_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [31:0]    x,
  input  logic [N_W-1:0] n,
  output logic [31:0]    mul_a,
  output logic [31:0]    mul_b,
  input  logic [31:0]    mul_c,
  output logic [31:0]    result,
  output logic           done,
  output logic           busy
);

  localparam logic [31:0] ONE_F = 32'h3F80_0000;
  localparam int          CNT_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_WAIT, S_DONE} state_t;
  typedef enum logic {OP_ACC, OP_SQ} op_t;

  state_t           state, state_nxt;
  op_t              op, op_nxt;
  logic [31:0]      acc, acc_nxt;
  logic [31:0]      base, base_nxt;
  logic [N_W-1:0]   e, e_nxt;
  logic             sgn, sgn_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      mul_a_nxt, mul_b_nxt, result_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op     <= OP_ACC;
      acc    <= '0;
      base   <= '0;
      e      <= '0;
      sgn    <= 1'b0;
      cnt    <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      op     <= op_nxt;
      acc    <= acc_nxt;
      base   <= base_nxt;
      e      <= e_nxt;
      sgn    <= sgn_nxt;
      cnt    <= cnt_nxt;
      mul_a  <= mul_a_nxt;
      mul_b  <= mul_b_nxt;
      result <= result_nxt;
    end
  end

  // NOTE: every signal assigned here gets a default first so no path infers a latch.
  always_comb begin
    state_nxt  = state;
    op_nxt     = op;
    acc_nxt    = acc;
    base_nxt   = base;
    e_nxt      = e;
    sgn_nxt    = sgn;
    cnt_nxt    = cnt;
    mul_a_nxt  = mul_a;
    mul_b_nxt  = mul_b;
    result_nxt = result;

    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef POW_ZERO_BYPASS_EN
          // Zero/denormal base with nonzero exponent is a signed zero; skip the multiplier.
          if ((x[30:23] == 8'h00) && (n != '0)) begin
            result_nxt = {x[31] & n[0], 31'b0};
            state_nxt  = S_DONE;
          end else begin
            acc_nxt   = ONE_F;
            base_nxt  = {1'b0, x[30:0]};
            e_nxt     = n;
            sgn_nxt   = x[31] & n[0];
            state_nxt = S_STEP;
          end
`else
          acc_nxt   = ONE_F;
          base_nxt  = {1'b0, x[30:0]};
          e_nxt     = n;
          sgn_nxt   = x[31] & n[0];
          state_nxt = S_STEP;
`endif
        end
      end

      S_STEP: begin
        cnt_nxt = '0;
        if (e == '0) begin
          result_nxt = {sgn, acc[30:0]};
          state_nxt  = S_DONE;
        end else if (e[0]) begin
          mul_a_nxt = acc;
          mul_b_nxt = base;
          op_nxt    = OP_ACC;
          state_nxt = S_WAIT;
        end else begin
          mul_a_nxt = base;
          mul_b_nxt = base;
          op_nxt    = OP_SQ;
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        // Product is valid on the last WAIT cycle, MUL_LAT edges after operand launch.
        if (cnt == CNT_LAST) begin
          if (op == OP_ACC) begin
            acc_nxt   = mul_c;
            e_nxt[0]  = 1'b0;
          end else begin
            base_nxt  = mul_c;
            e_nxt     = e >> 1;
          end
          state_nxt = S_STEP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      S_DONE: state_nxt = S_IDLE;

      default: state_nxt = S_IDLE;
    endcase
  end

  assign done = (state == S_DONE);
  assign busy = (state == S_STEP) || (state == S_WAIT);

endmodule

// File: tb/tb_pow_seq.sv
// Directed bench for pow_seq with a one-stage truncating float multiplier model.
module tb_pow_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x = '0;
  logic [7:0]  n = '0;
  logic [31:0] mul_a, mul_b, result;
  logic [31:0] mul_c = '0;
  logic        done, busy;

  int errs = 0;
  int checks = 0;
  int chg_cnt = 0;
  logic [63:0] prev_ops = '0;

  pow_seq #(.N_W(8), .MUL_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .n(n),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Magnitude-only multiply, truncated mantissa, zero exponent treated as zero.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    int          ex;
    logic [22:0] m;
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return 32'h0;
    p  = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    ex = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m  = p[46:24];
      ex = ex + 1;
    end else begin
      m  = p[45:23];
    end
    return {1'b0, ex[7:0], m};
  endfunction

  always @(posedge clk) mul_c <= fmul(mul_a, mul_b);

  always @(negedge clk) begin
    if ({mul_a, mul_b} != prev_ops) chg_cnt = chg_cnt + 1;
    prev_ops = {mul_a, mul_b};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errs = errs + 1;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Launch one request and follow it to done; optionally inject a stray start at cycle inj.
  task automatic do_op(input string tag, input logic [31:0] xv, input logic [7:0] nv,
                       input int exp_cyc, input logic [31:0] exp_res, input int exp_iss,
                       input int inj);
    int c;
    int chg0;
    bit seen;
    @(negedge clk);
    x = xv; n = nv; start = 1'b1;
    chg0 = chg_cnt;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    seen = 1'b0;
    check({tag, "_busy_c1"}, {31'b0, busy}, (exp_cyc > 1) ? 32'd1 : 32'd0);
    while (c < 300 && !seen) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (c == inj) begin
          start = 1'b1; x = 32'h4040_0000; n = 8'd1;
        end else if (c == inj + 1) begin
          start = 1'b0;
        end
        @(negedge clk);
        c = c + 1;
      end
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, c, exp_cyc);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
    check({tag, "_issues"}, chg_cnt - chg0, exp_iss);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_result", result, 32'h0);
    check("rst_mul_a", mul_a, 32'h0);
    check("rst_mul_b", mul_b, 32'h0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;

    do_op("n0", 32'h4120_0000, 8'd0, 2, 32'h3F80_0000, 0, 0);
    check("n0_mul_a", mul_a, 32'h0);
    check("n0_mul_b", mul_b, 32'h0);

    do_op("pow2_10", 32'h4000_0000, 8'd10, 17, 32'h4480_0000, 5, 0);
    do_op("neg_n3", 32'hBFC0_0000, 8'd3, 11, 32'hC058_0000, 3, 0);
    do_op("neg_n2", 32'hBFC0_0000, 8'd2, 8, 32'h4010_0000, 2, 0);
    do_op("ignore", 32'h4000_0000, 8'd10, 17, 32'h4480_0000, 5, 5);

    // Abort during the first WAIT cycle.
    @(negedge clk);
    x = 32'h4000_0000; n = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_mul_a", mul_a, 32'h0);
    check("abort_mul_b", mul_b, 32'h0);
    check("abort_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after_rst", 32'h4000_0000, 8'd1, 5, 32'h4000_0000, 1, 0);

`ifdef POW_ZERO_BYPASS_EN
    do_op("bypass", 32'h8000_0000, 8'd3, 1, 32'h8000_0000, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
